instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Fetch/issue controller that sequences 32-bit opcodes from an instruction ROM into the decode/execute unit, one instruction at a time.
- Sits between the instruction memory (req/rvalid interface) and the decode unit (valid/ready issue, done completion).
- Replaces testbench-driven opcode stepping.
- Owns the program counter, detects the halt opcode and end of program, and counts retired instructions.

Parameters:
- ADDR_W, 8, width of the PC and ROM address.
- PROG_LEN, 4, number of ROM words in the program; last fetched address is PROG_LEN-1.
- CNT_W, 16, width of the retired-instruction counter.
- HALT_OPCODE, 32'hFFFF_FFFF, opcode value that stops sequencing without being issued.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run from PC 0; sampled in IDLE/HALT only.
- mem_req  out  1  one-cycle read request to the ROM.
- mem_addr  out  ADDR_W  ROM read address, valid with mem_req.
- mem_rdata  in  32  ROM read data.
- mem_rvalid  in  1  mem_rdata valid; latency ≥1 cycle after mem_req.
- opcode  out  32  instruction presented to decode.
- opcode_valid  out  1  opcode valid.
- exec_ready  in  1  decode accepts opcode when opcode_valid & exec_ready.
- exec_done  in  1  one-cycle pulse: issued instruction completed.
- pc  out  ADDR_W  current program counter.
- busy  out  1  high in FETCH/WAIT_MEM/ISSUE/WAIT_DONE.
- halted  out  1  high in HALT.
- instr_count  out  CNT_W  instructions retired (exec_done seen) this run.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_req=0, mem_addr=0, opcode=0, opcode_valid=0, pc=0, busy=0, halted=0, instr_count=0. Takes effect immediately, mid-operation included; any outstanding memory/exec response is dropped.
- IDLE: start=1 -> FETCH, pc=0, instr_count=0.
- FETCH, 1 cycle: mem_req=1, mem_addr=pc -> WAIT_MEM.
- WAIT_MEM:
  - Wait for mem_rvalid. mem_rvalid in any other state is ignored.
  - On rvalid with mem_rdata==HALT_OPCODE -> HALT; opcode is not updated and never issued.
  - Otherwise opcode<=mem_rdata, opcode_valid<=1 -> ISSUE.
- ISSUE:
  - opcode and opcode_valid hold stable until exec_ready=1.
  - Handshake cycle: opcode_valid<=0 next cycle.
  - If exec_done=1 in the same cycle, treat as completion (go to the completion step); else -> WAIT_DONE.
- WAIT_DONE: wait for exec_done; exec_done outside ISSUE/WAIT_DONE is ignored.
- Completion:
  - instr_count += 1, saturating at 2^CNT_W-1.
  - If pc==PROG_LEN-1 -> HALT, pc unchanged. Else pc+=1 -> FETCH.
- HALT:
  - halted=1, busy=0; opcode keeps its last value.
  - start=1 -> FETCH with pc=0, instr_count=0, halted=0.
- start while busy is ignored.
- Latency per instruction with 1-cycle ROM and immediate ready/done: FETCH, WAIT_MEM, ISSUE+done = 3 cycles. The next mem_req occurs 3 cycles after the previous one.
- All outputs are registered; no combinational input-to-output path.

Decomposition:
- Shared package seq_pkg holds:
  - state encoding localparams: IDLE, FETCH, WAIT_MEM, ISSUE, WAIT_DONE, HALT (3-bit);
  - default HALT_OPCODE constant.
- One sub-module, sat_counter (parameter W; inputs clr, inc; output count). Used for instr_count.
- PC logic stays inline.

Test Plan:
- Reset mid-run: assert rst_n=0 during ISSUE -> same cycle: opcode_valid=0, busy=0, pc=0, instr_count=0. After release, state is IDLE with no mem_req until start.
- Nominal run: ROM = {0x00000011, 0x00000022, 0x00000033, 0x00000044}; 1-cycle ROM; exec_ready=1; exec_done in the handshake cycle; start pulse -> opcodes issued in order, mem_req every 3 cycles. End state: halted=1, pc=3, instr_count=4.
- Halt opcode: ROM[1]=0xFFFFFFFF -> only 0x00000011 issued. End state: halted=1, pc=1, instr_count=1, opcode stays 0x00000011.
- Backpressure: hold exec_ready=0 for 5 cycles on instr 0 -> opcode_valid=1 and opcode=0x00000011 stable all 5 cycles; exactly one handshake.
- Delayed completion and stray inputs: exec_done 4 cycles after handshake, mem_rvalid pulsed during WAIT_DONE, start pulsed while busy -> no refetch, no double count, run unaffected.
- Restart: start in HALT after the nominal run -> instr_count=0, pc=0, halted=0 next cycle; second run repeats identical results.

Source files
------------

// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Purpose : shared definitions for the instruction sequencer: the 3-bit state
//           encoding and the default halt opcode.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t FETCH     = 3'd1;
  localparam state_t WAIT_MEM  = 3'd2;
  localparam state_t ISSUE     = 3'd3;
  localparam state_t WAIT_DONE = 3'd4;
  localparam state_t HALT      = 3'd5;

  localparam logic [31:0] DEFAULT_HALT_OPCODE = 32'hFFFF_FFFF;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Purpose : W-bit up counter that sticks at its maximum value instead of
//           wrapping. Clear has priority over increment.
// Ports   : clk   - clock, rising edge
//           rst_n - asynchronous active-low reset (count -> 0)
//           clr   - synchronous clear
//           inc   - increment request
//           count - current (registered) count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_COUNT = '1;

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != MAX_COUNT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
// Purpose : fetch/issue controller. Reads opcodes from the instruction ROM one
//           at a time, presents each to the decode unit with a valid/ready
//           handshake, waits for its completion pulse, then moves to the next
//           address. Stops on the halt opcode or after the last program word.
// Ports   : clk, rst_n             - clock / async active-low reset
//           start                  - begin a run from PC 0 (IDLE/HALT only)
//           mem_req, mem_addr      - one-cycle ROM read request and address
//           mem_rdata, mem_rvalid  - ROM read response
//           opcode, opcode_valid   - instruction offered to decode
//           exec_ready             - decode accepts the offered opcode
//           exec_done              - completion pulse for the issued opcode
//           pc                     - program counter
//           busy, halted           - run status
//           instr_count            - instructions retired in this run
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter int          PROG_LEN    = 4,
  parameter int          CNT_W       = 16,
  parameter logic [31:0] HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [31:0]       opcode,
  output logic              opcode_valid,
  input  logic              exec_ready,
  input  logic              exec_done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_req;
  logic [31:0]       r_opcode;
  logic [31:0]       w_opcode_next;
  logic              r_opcode_valid;
  logic              w_opcode_valid_next;
  logic              r_busy;
  logic              r_halted;
  logic              w_run_start;
  logic              w_complete;

  // State register plus the registered copies of every output. Status outputs
  // are decoded from the *next* state so they line up with the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_pc           <= '0;
      r_mem_req      <= 1'b0;
      r_mem_addr     <= '0;
      r_opcode       <= '0;
      r_opcode_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_halted       <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_pc           <= w_pc_next;
      r_mem_req      <= (w_state_next == FETCH);
      if (w_state_next == FETCH) begin
        r_mem_addr <= w_pc_next;
      end
      r_opcode       <= w_opcode_next;
      r_opcode_valid <= w_opcode_valid_next;
      r_busy         <= (w_state_next == FETCH) || (w_state_next == WAIT_MEM) ||
                        (w_state_next == ISSUE) || (w_state_next == WAIT_DONE);
      r_halted       <= (w_state_next == HALT);
    end
  end

  // Next-state logic. Completion may happen in the handshake cycle itself, so
  // it is resolved once after the case statement.
  always_comb begin
    w_state_next = r_state;
    w_run_start  = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      IDLE, HALT: begin
        if (start) begin
          w_state_next = FETCH;
          w_run_start  = 1'b1;
        end
      end
      FETCH: w_state_next = WAIT_MEM;
      WAIT_MEM: begin
        if (mem_rvalid) begin
          w_state_next = (mem_rdata == HALT_OPCODE) ? HALT : ISSUE;
        end
      end
      ISSUE: begin
        if (exec_ready) begin
          if (exec_done) begin
            w_complete = 1'b1;
          end else begin
            w_state_next = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: begin
        if (exec_done) begin
          w_complete = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (w_complete) begin
      w_state_next = (r_pc == LAST_PC) ? HALT : FETCH;
    end
  end

  // Datapath next values: PC, opcode latch and the issue valid flag.
  always_comb begin
    w_pc_next           = r_pc;
    w_opcode_next       = r_opcode;
    w_opcode_valid_next = r_opcode_valid;
    if (w_run_start) begin
      w_pc_next = '0;
    end else if (w_complete && (r_pc != LAST_PC)) begin
      w_pc_next = r_pc + 1'b1;
    end
    // The halt opcode never reaches the opcode register.
    if ((r_state == WAIT_MEM) && mem_rvalid && (mem_rdata != HALT_OPCODE)) begin
      w_opcode_next       = mem_rdata;
      w_opcode_valid_next = 1'b1;
    end else if ((r_state == ISSUE) && exec_ready) begin
      w_opcode_valid_next = 1'b0;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_retired_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_run_start),
    .inc   (w_complete),
    .count (instr_count)
  );

  assign mem_req      = r_mem_req;
  assign mem_addr     = r_mem_addr;
  assign opcode       = r_opcode;
  assign opcode_valid = r_opcode_valid;
  assign pc           = r_pc;
  assign busy         = r_busy;
  assign halted       = r_halted;

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
// Purpose : self-checking bench for instr_sequencer. A 1-cycle ROM responder
//           and an execute-unit responder drive the DUT; a transaction-level
//           model checks every output every cycle, and directed scenarios add
//           hand-computed end-state expectations.
// Ports   : none (top-level bench).
// -----------------------------------------------------------------------------
module tb_instr_sequencer;
  import seq_pkg::*;

  localparam int          ADDR_W   = 8;
  localparam int          PROG_LEN = 4;
  localparam int          CNT_W    = 16;
  localparam logic [31:0] HOP      = 32'hFFFF_FFFF;

  logic              clk          = 1'b0;
  logic              rst_n        = 1'b0;
  logic              start        = 1'b0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata    = 32'h0;
  logic              mem_rvalid   = 1'b0;
  logic [31:0]       opcode;
  logic              opcode_valid;
  logic              exec_ready   = 1'b0;
  logic              exec_done    = 1'b0;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;
  logic [CNT_W-1:0]  instr_count;

  instr_sequencer #(
    .ADDR_W      (ADDR_W),
    .PROG_LEN    (PROG_LEN),
    .CNT_W       (CNT_W),
    .HALT_OPCODE (HOP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid),
    .opcode       (opcode),
    .opcode_valid (opcode_valid),
    .exec_ready   (exec_ready),
    .exec_done    (exec_done),
    .pc           (pc),
    .busy         (busy),
    .halted       (halted),
    .instr_count  (instr_count)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- environment ----------------
  logic [31:0] rom [256];
  logic        stray_rv   = 1'b0;
  int          done_delay = 0;

  // ROM: answers a request seen in one cycle during the following cycle.
  initial begin : rom_proc
    logic              pend;
    logic [ADDR_W-1:0] a;
    forever begin
      @(negedge clk);
      pend = mem_req;
      a    = mem_addr;
      @(posedge clk);
      #2;
      if (!rst_n) pend = 1'b0;
      mem_rvalid = pend | stray_rv;
      mem_rdata  = pend ? rom[a] : (stray_rv ? 32'h0BAD_0BAD : 32'h0);
    end
  end

  // Execute unit: done in the handshake cycle, or done_delay cycles later.
  initial begin : exec_proc
    int cd;
    cd = 0;
    forever begin
      @(posedge clk);
      #2;
      exec_done = 1'b0;
      if (!rst_n) begin
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) exec_done = 1'b1;
        end
        if (opcode_valid && exec_ready) begin
          if (done_delay == 0) exec_done = 1'b1;
          else cd = done_delay;
        end
      end
    end
  end

  // ---------------- transaction-level model + per-cycle compare ----------------
  int          cyc = 0;
  logic [31:0] hs_log [$];
  int          req_cyc [$];

  bit          m_run, m_halted, m_expect_req, m_await_mem, m_valid, m_out;
  int          m_pc, m_count;
  logic [31:0] m_opcode;

  initial begin : monitor
    bit req_now;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_run = 0; m_halted = 0; m_expect_req = 0; m_await_mem = 0;
        m_valid = 0; m_out = 0; m_pc = 0; m_count = 0; m_opcode = 32'h0;
      end else begin
        chk("busy", {31'b0, busy}, {31'b0, m_run});
        chk("halted", {31'b0, halted}, {31'b0, m_halted});
        chk("pc", 32'(pc), 32'(m_pc));
        chk("instr_count", 32'(instr_count), 32'(m_count));
        chk("mem_req", {31'b0, mem_req}, {31'b0, m_expect_req});
        chk("opcode_valid", {31'b0, opcode_valid}, {31'b0, m_valid});
        chk("opcode", opcode, m_opcode);
        if (mem_req) begin
          chk("mem_addr", 32'(mem_addr), 32'(m_pc));
          req_cyc.push_back(cyc);
        end

        req_now      = m_expect_req;
        m_expect_req = 0;
        if (!m_run) begin
          if (start) begin
            m_run = 1; m_halted = 0; m_pc = 0; m_count = 0; m_expect_req = 1;
          end
        end else if (req_now) begin
          m_await_mem = 1;
        end else if (m_await_mem) begin
          if (mem_rvalid) begin
            m_await_mem = 0;
            if (mem_rdata == HOP) begin
              m_run = 0; m_halted = 1;
            end else begin
              m_opcode = mem_rdata; m_valid = 1;
            end
          end
        end else begin
          if (m_valid && exec_ready) begin
            m_valid = 0; m_out = 1;
            hs_log.push_back(m_opcode);
          end
          if (m_out && exec_done) begin
            m_out = 0;
            if (m_count < (1 << CNT_W) - 1) m_count++;
            if (m_pc == PROG_LEN - 1) begin
              m_run = 0; m_halted = 1;
            end else begin
              m_pc++; m_expect_req = 1;
            end
          end
        end
      end
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_rom(input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3);
    rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
  endtask

  task automatic clear_logs();
    hs_log.delete();
    req_cyc.delete();
  endtask

  task automatic wait_halted(input int lim);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    chk("wait_halted", {31'b0, halted}, 32'h1);
  endtask

  task automatic wait_opcode_valid(input int lim);
    int n;
    n = 0;
    while (opcode_valid !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    chk("wait_opcode_valid", {31'b0, opcode_valid}, 32'h1);
  endtask

  task automatic wait_hs(input int cnt, input int lim);
    int n;
    n = 0;
    while (hs_log.size() < cnt && n < lim) begin
      tick();
      n++;
    end
    chk("wait_handshake", 32'(hs_log.size()), 32'(cnt));
  endtask

  task automatic check_full_run(input string tag, input int gap);
    chk({tag, "_pc"}, 32'(pc), 32'd3);
    chk({tag, "_count"}, 32'(instr_count), 32'd4);
    chk({tag, "_opcode"}, opcode, 32'h0000_0044);
    chk({tag, "_hs_n"}, 32'(hs_log.size()), 32'd4);
    if (hs_log.size() == 4) begin
      chk({tag, "_hs0"}, hs_log[0], 32'h0000_0011);
      chk({tag, "_hs1"}, hs_log[1], 32'h0000_0022);
      chk({tag, "_hs2"}, hs_log[2], 32'h0000_0033);
      chk({tag, "_hs3"}, hs_log[3], 32'h0000_0044);
    end
    chk({tag, "_req_n"}, 32'(req_cyc.size()), 32'd4);
    if (req_cyc.size() >= 2) begin
      chk({tag, "_req_gap"}, 32'(req_cyc[1] - req_cyc[0]), 32'(gap));
    end
    $display("run %s: pc=%0d count=%0d opcode=%h handshakes=%0d", tag, pc, instr_count,
             opcode, hs_log.size());
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
    load_rom(32'h11, 32'h22, 32'h33, 32'h44);

    // Reset state
    repeat (3) tick();
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_opcode_valid", {31'b0, opcode_valid}, 32'd0);
    chk("rst_opcode", opcode, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    $display("reset: pc=%0d busy=%0d halted=%0d count=%0d", pc, busy, halted, instr_count);

    // Nominal run
    exec_ready = 1'b1;
    clear_logs();
    pulse_start();
    wait_halted(100);
    if (req_cyc.size() == 4) begin
      chk("nom_req_gap2", 32'(req_cyc[2] - req_cyc[1]), 32'd3);
      chk("nom_req_gap3", 32'(req_cyc[3] - req_cyc[2]), 32'd3);
    end
    check_full_run("nominal", 3);

    // Restart from HALT
    clear_logs();
    pulse_start();
    chk("restart_count", 32'(instr_count), 32'd0);
    chk("restart_pc", 32'(pc), 32'd0);
    chk("restart_halted", {31'b0, halted}, 32'd0);
    chk("restart_busy", {31'b0, busy}, 32'd1);
    wait_halted(100);
    check_full_run("restart", 3);

    // Halt opcode in the middle of the program
    load_rom(32'h11, HOP, 32'h33, 32'h44);
    clear_logs();
    pulse_start();
    wait_halted(100);
    chk("haltop_pc", 32'(pc), 32'd1);
    chk("haltop_count", 32'(instr_count), 32'd1);
    chk("haltop_opcode", opcode, 32'h0000_0011);
    chk("haltop_hs_n", 32'(hs_log.size()), 32'd1);
    chk("haltop_req_n", 32'(req_cyc.size()), 32'd2);
    $display("run haltop: pc=%0d count=%0d opcode=%h", pc, instr_count, opcode);

    // Backpressure on instruction 0
    load_rom(32'h11, 32'h22, 32'h33, 32'h44);
    clear_logs();
    exec_ready = 1'b0;
    pulse_start();
    wait_opcode_valid(20);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, opcode_valid}, 32'd1);
      chk("bp_opcode", opcode, 32'h0000_0011);
      tick();
    end
    chk("bp_no_hs", 32'(hs_log.size()), 32'd0);
    exec_ready = 1'b1;
    wait_halted(100);
    check_full_run("backpressure", 8);

    // Delayed completion with stray rvalid and start while busy
    clear_logs();
    done_delay = 4;
    pulse_start();
    wait_hs(1, 20);
    stray_rv = 1'b1;
    start    = 1'b1;
    tick();
    stray_rv = 1'b0;
    start    = 1'b0;
    chk("delay_busy", {31'b0, busy}, 32'd1);
    wait_halted(200);
    check_full_run("delayed", 7);
    done_delay = 0;

    // Reset in the middle of a run, while instruction 2 is waiting in ISSUE
    clear_logs();
    exec_ready = 1'b1;
    pulse_start();
    wait_hs(2, 40);
    exec_ready = 1'b0;
    wait_opcode_valid(20);
    chk("midrst_pre_pc", 32'(pc), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, opcode_valid}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_pc", 32'(pc), 32'd0);
    chk("midrst_count", 32'(instr_count), 32'd0);
    chk("midrst_opcode", opcode, 32'd0);
    $display("midrun reset: valid=%0d busy=%0d pc=%0d count=%0d", opcode_valid, busy, pc,
             instr_count);
    tick();
    tick();
    rst_n = 1'b1;
    exec_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("post_rst_busy", {31'b0, busy}, 32'd0);
    end

    // Fresh run from IDLE after the reset
    clear_logs();
    pulse_start();
    wait_halted(100);
    check_full_run("after_reset", 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
